ahb_apb_bridge_nslv: RTL and testbench
======================================

# ahb_apb_bridge_nslv

Parametrised AHB-Lite to APB bridge serving up to 16 APB peripherals from a single AHB slave port. It decodes the top address nibble to a one-hot PSEL and honours HTRANS/HREADY pipelining. Write data is captured in the correct AHB data phase. APB wait states are stretched onto HREADYOUT, and undecoded addresses (plus optional PSLVERR) return the two-cycle AHB ERROR response. It sits between the AHB interconnect and the peripheral cluster (GPIO, timers, UART).

## Interface
- NUM_SLV, 2, number of APB slaves (1..16)
- ADDR_W, 32, address width (≥ 5)
- DATA_W, 32, data width
- iHCLK  in  1  bridge clock (AHB and APB share it)
- iHRESETn  in  1  asynchronous active-low reset
- iHSEL  in  1  bridge selected by the AHB decoder
- iHADDR  in  ADDR_W  address phase address; slave index = iHADDR[ADDR_W-1:ADDR_W-4]
- iHTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- iHWRITE  in  1  1 = write
- iHSIZE  in  3  forwarded nowhere; accepted for protocol completeness
- iHWDATA  in  DATA_W  write data (data phase)
- iHREADY  in  1  bus-level HREADY (previous transfer completing)
- oHREADYOUT  out  1  bridge ready
- oHRDATA  out  DATA_W  registered read data
- oHRESP  out  2  OKAY=00, ERROR=01
- oPADDR  out  ADDR_W  APB address
- oPSEL  out  NUM_SLV  one-hot select
- oPENABLE  out  1  APB access phase
- oPWRITE  out  1  APB direction
- oPWDATA  out  DATA_W  APB write data
- iPREADY  in  NUM_SLV  per-slave ready
- iPRDATA  in  NUM_SLV*DATA_W  per-slave read data, slave k at [k*DATA_W +: DATA_W]
- iPSLVERR  in  NUM_SLV  per-slave error

## Operation
- Accept when iHSEL & iHTRANS[1] & iHREADY in an accepting state (IDLE, ERR2). Capture address, write flag and slave index. IDLE/BUSY transfers get a zero-wait OKAY with no APB activity.
- States: IDLE, WDAT, SETUP, ACCESS, ERR1, ERR2.
- IDLE/ERR2, accept:
  - index < NUM_SLV write → WDAT.
  - index < NUM_SLV read → SETUP.
  - index ≥ NUM_SLV → ERR1.
  - No accept → IDLE.
- WDAT: latch iHWDATA into oPWDATA → SETUP.
- SETUP: oPSEL one-hot, oPENABLE=0 → ACCESS.
- ACCESS: oPENABLE=1. The selected iPREADY=0 holds ACCESS with all APB outputs stable.
  - PREADY=1, no error → IDLE; capture the selected iPRDATA into oHRDATA (reads only).
  - PREADY=1 with error → ERR1.
- ERR1: oHRESP=ERROR, oHREADYOUT=0. ERR2: oHRESP=ERROR, oHREADYOUT=1.
- oHREADYOUT=1 only in IDLE and ERR2. oHRESP=OKAY outside ERR1/ERR2.
- On leaving ACCESS or ERR: oPSEL=0, oPENABLE=0. oPADDR, oPWRITE and oPWDATA hold their last values.
- oHRDATA holds until the next read completion. Writes and errors leave it unchanged.

## Timing
- Reset (async, immediate, including mid-transfer): state IDLE, oHREADYOUT=1, oHRESP=00, oHRDATA=0, oPSEL=0, oPENABLE=0, oPADDR=0, oPWRITE=0, oPWDATA=0.
- Read accepted at cycle T: SETUP T+1, ACCESS T+2, oHREADYOUT=1 with data at T+3 when PREADY=1. Minimum 2 AHB wait states.
- Write accepted at T: WDAT T+1, SETUP T+2, ACCESS T+3, done at T+4. Minimum 3 wait states.
- Each PREADY-low cycle in ACCESS adds one wait state.
- Back-to-back: a new transfer presented in the completion cycle (IDLE or ERR2) is accepted that cycle.
- Decode miss accepted at T: ERR1 at T+1, ERR2 at T+2.
- All outputs are registered. There is no combinational path from iPREADY to oHREADYOUT.

## Configuration
- AHB_APB_PSLVERR_EN defined: iPSLVERR of the selected slave, sampled with PREADY=1 in ACCESS, routes to ERR1/ERR2. oHRDATA is not updated on an errored read.
- Not defined: iPSLVERR is ignored and every decoded transfer completes OKAY. Decode-miss ERROR is always present.

## Structure
- Package ahb_apb_pkg holds:
  - HTRANS encodings and HRESP encodings.
  - The bridge state encoding.
  - The SLV_IDX_W=4 decode-field width.
- Sub-module apb_slave_mux: a combinational index-driven mux of iPREADY, iPRDATA and iPSLVERR to a single ready/rdata/slverr.

## Test plan
- Read, NUM_SLV=2: addr 0x1000_0004, slave 1 PREADY=1, PRDATA=0xCAFE_F00D → oPSEL=2'b10 at T+1, oPENABLE at T+2, oHREADYOUT=1 and oHRDATA=0xCAFE_F00D at T+3, HRESP OKAY.
- Write: addr 0x0000_0010, HWDATA=0x1234_5678 in the data phase → oPWDATA=0x1234_5678 from T+2, oPWRITE=1, oPSEL=2'b01, completion at T+4.
- Wait states: slave 0 holds PREADY=0 for 3 ACCESS cycles → oHREADYOUT low 5 cycles on a read, APB outputs stable throughout.
- Decode miss: addr 0xF000_0000 → no oPSEL. oHRESP=01 with oHREADYOUT=0 at T+1, oHRESP=01 with oHREADYOUT=1 at T+2.
- PSLVERR (macro on): read with PSLVERR=1 → ERROR two-cycle response, oHRDATA unchanged. With the macro off, the same stimulus → OKAY.
- iHRESETn pulsed low during ACCESS → all outputs return to reset values immediately. The first post-reset NONSEQ is accepted normally. An IDLE HTRANS yields no PSEL.

Source files
------------

// File: rtl/ahb_apb_bridge_nslv_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge: HTRANS/HRESP codes, FSM states, decode width.
package ahb_apb_pkg;

    localparam int SLV_IDX_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDAT,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

    // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY get a zero-wait OKAY.
    function automatic logic htransActive(input logic [1:0] htrans);
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: htransActive = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  htransActive = 1'b0;
            default:                   htransActive = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_nslv_if.sv
// AHB slave port plus APB master port of the bridge; slave = bridge side, master = system side.
interface ahb_apb_bridge_nslv_if #(
    parameter int NUM_SLV = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic                      iHSEL;
    logic [ADDR_W-1:0]         iHADDR;
    logic [1:0]                iHTRANS;
    logic                      iHWRITE;
    logic [2:0]                iHSIZE;
    logic [DATA_W-1:0]         iHWDATA;
    logic                      iHREADY;
    logic                      oHREADYOUT;
    logic [DATA_W-1:0]         oHRDATA;
    logic [1:0]                oHRESP;
    logic [ADDR_W-1:0]         oPADDR;
    logic [NUM_SLV-1:0]        oPSEL;
    logic                      oPENABLE;
    logic                      oPWRITE;
    logic [DATA_W-1:0]         oPWDATA;
    logic [NUM_SLV-1:0]        iPREADY;
    logic [NUM_SLV*DATA_W-1:0] iPRDATA;
    logic [NUM_SLV-1:0]        iPSLVERR;

    modport slave (
        input  iHSEL, iHADDR, iHTRANS, iHWRITE, iHSIZE, iHWDATA, iHREADY,
        output oHREADYOUT, oHRDATA, oHRESP,
        output oPADDR, oPSEL, oPENABLE, oPWRITE, oPWDATA,
        input  iPREADY, iPRDATA, iPSLVERR
    );

    modport master (
        output iHSEL, iHADDR, iHTRANS, iHWRITE, iHSIZE, iHWDATA, iHREADY,
        input  oHREADYOUT, oHRDATA, oHRESP,
        input  oPADDR, oPSEL, oPENABLE, oPWRITE, oPWDATA,
        output iPREADY, iPRDATA, iPSLVERR
    );

endinterface

// File: rtl/ahb_apb_bridge_nslv_apb_slave_mux.sv
// Combinational selection of the addressed APB slave's ready, read data and error.
module apb_slave_mux
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLV = 2,
    parameter int DATA_W  = 32
) (
    input  logic [SLV_IDX_W-1:0]      slvIdx,
    input  logic [NUM_SLV-1:0]        pReady,
    input  logic [NUM_SLV*DATA_W-1:0] pRdata,
    input  logic [NUM_SLV-1:0]        pSlvErr,
    output logic                      selReady,
    output logic [DATA_W-1:0]         selRdata,
    output logic                      selSlvErr
);

    always_comb begin
        selReady  = 1'b0;
        selRdata  = '0;
        selSlvErr = 1'b0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (slvIdx == SLV_IDX_W'(k)) begin
                selReady  = pReady[k];
                selRdata  = pRdata[k*DATA_W +: DATA_W];
                selSlvErr = pSlvErr[k];
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_nslv.sv
// AHB-Lite to APB bridge for up to 16 slaves decoded from the top address nibble.
// Latency: reads 2 wait states, writes 3, plus one per PREADY-low ACCESS cycle; decode miss = 2-cycle ERROR.
// Backpressure: APB waits stretch oHREADYOUT; AHB_APB_PSLVERR_EN routes PSLVERR to the ERROR response.
module ahb_apb_bridge_nslv
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLV = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                   iHCLK,
    input  logic                   iHRESETn,
    ahb_apb_bridge_nslv_if.slave   bus
);

    bridge_state_t          state, nxtState;
    logic [SLV_IDX_W-1:0]   addrIdx, idxQ, idxNxt;
    logic                   accept, decodeHit, apbErr;
    logic                   selReady, selSlvErr;
    logic [DATA_W-1:0]      selRdata;
    logic [NUM_SLV-1:0]     pselOneHot;

    logic                   hreadyQ;
    logic [1:0]             hrespQ;
    logic [DATA_W-1:0]      hrdataQ;
    logic [ADDR_W-1:0]      paddrQ;
    logic [NUM_SLV-1:0]     pselQ;
    logic                   penableQ, pwriteQ;
    logic [DATA_W-1:0]      pwdataQ;

    assign addrIdx   = bus.iHADDR[ADDR_W-1 -: SLV_IDX_W];
    assign decodeHit = int'(addrIdx) < NUM_SLV;
    assign accept    = (state == ST_IDLE || state == ST_ERR2) && bus.iHSEL
                       && htransActive(bus.iHTRANS) && bus.iHREADY;
    assign idxNxt    = accept ? addrIdx : idxQ;

    apb_slave_mux #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W)) uMux (
        .slvIdx    (idxQ),
        .pReady    (bus.iPREADY),
        .pRdata    (bus.iPRDATA),
        .pSlvErr   (bus.iPSLVERR),
        .selReady  (selReady),
        .selRdata  (selRdata),
        .selSlvErr (selSlvErr)
    );

`ifdef AHB_APB_PSLVERR_EN
    assign apbErr = selSlvErr;
`else
    assign apbErr = 1'b0;
`endif

    logic unusedOk;
    assign unusedOk = &{1'b0, bus.iHSIZE, selSlvErr};

    always_comb begin
        pselOneHot = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (idxNxt == SLV_IDX_W'(k)) pselOneHot[k] = 1'b1;
        end
    end

    always_comb begin
        nxtState = state;
        case (state)
            ST_IDLE, ST_ERR2: begin
                if (!accept)            nxtState = ST_IDLE;
                else if (!decodeHit)    nxtState = ST_ERR1;
                else if (bus.iHWRITE)   nxtState = ST_WDAT;
                else                    nxtState = ST_SETUP;
            end
            ST_WDAT:   nxtState = ST_SETUP;
            ST_SETUP:  nxtState = ST_ACCESS;
            ST_ACCESS: begin
                if (selReady) nxtState = apbErr ? ST_ERR1 : ST_IDLE;
            end
            ST_ERR1:   nxtState = ST_ERR2;
            default:   nxtState = ST_IDLE;
        endcase
    end

    always_ff @(posedge iHCLK or negedge iHRESETn) begin
        if (!iHRESETn) state <= ST_IDLE;
        else           state <= nxtState;
    end

    // Every output is a flop loaded from the next state, so PREADY never reaches HREADYOUT combinationally.
    always_ff @(posedge iHCLK or negedge iHRESETn) begin
        if (!iHRESETn) begin
            idxQ     <= '0;
            hreadyQ  <= 1'b1;
            hrespQ   <= HRESP_OKAY;
            hrdataQ  <= '0;
            paddrQ   <= '0;
            pselQ    <= '0;
            penableQ <= 1'b0;
            pwriteQ  <= 1'b0;
            pwdataQ  <= '0;
        end else begin
            if (accept) begin
                idxQ    <= addrIdx;
                paddrQ  <= bus.iHADDR;
                pwriteQ <= bus.iHWRITE;
            end
            if (state == ST_WDAT) pwdataQ <= bus.iHWDATA;
            if (state == ST_ACCESS && selReady && !apbErr && !pwriteQ) hrdataQ <= selRdata;
            pselQ    <= (nxtState == ST_SETUP || nxtState == ST_ACCESS) ? pselOneHot : '0;
            penableQ <= (nxtState == ST_ACCESS);
            hreadyQ  <= (nxtState == ST_IDLE || nxtState == ST_ERR2);
            hrespQ   <= (nxtState == ST_ERR1 || nxtState == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    assign bus.oHREADYOUT = hreadyQ;
    assign bus.oHRESP     = hrespQ;
    assign bus.oHRDATA    = hrdataQ;
    assign bus.oPADDR     = paddrQ;
    assign bus.oPSEL      = pselQ;
    assign bus.oPENABLE   = penableQ;
    assign bus.oPWRITE    = pwriteQ;
    assign bus.oPWDATA    = pwdataQ;

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// Bench for ahb_apb_bridge_nslv (NUM_SLV=2): AHB master + two APB slave models, queued expected responses.
module tb_ahb_apb_bridge_nslv;

    localparam logic [31:0] S0_DATA = 32'h5A5A_0001;
    localparam logic [31:0] S1_DATA = 32'hCAFE_F00D;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    int         stall0 = 0;
    int         stall1 = 0;
    int         accessCnt = 0;
    logic [1:0] slvErr = 2'b00;
    int         nChecks = 0;
    int         nErrors = 0;
    exp_t       expQ[$];

    logic [1:0]  obsPsel   [0:63];
    logic        obsPen    [0:63];
    logic [31:0] obsPaddr  [0:63];
    logic [31:0] obsPwdata [0:63];
    logic        obsPwrite [0:63];
    logic [1:0]  obsResp   [0:63];

    ahb_apb_bridge_nslv_if #(.NUM_SLV(2), .ADDR_W(32), .DATA_W(32)) bus ();

    ahb_apb_bridge_nslv #(.NUM_SLV(2), .ADDR_W(32), .DATA_W(32)) dut (
        .iHCLK    (clk),
        .iHRESETn (rstN),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    assign bus.iHREADY  = bus.oHREADYOUT;
    assign bus.iPRDATA  = {S1_DATA, S0_DATA};
    assign bus.iPSLVERR = slvErr;
    assign bus.iPREADY  = {accessCnt >= stall1, accessCnt >= stall0};

    always @(posedge clk) begin
        if (bus.oPENABLE) accessCnt <= accessCnt + 1;
        else              accessCnt <= 0;
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic recordObs(input int w);
        obsPsel[w]   = bus.oPSEL;
        obsPen[w]    = bus.oPENABLE;
        obsPaddr[w]  = bus.oPADDR;
        obsPwdata[w] = bus.oPWDATA;
        obsPwrite[w] = bus.oPWRITE;
        obsResp[w]   = bus.oHRESP;
    endtask

    // Drives one NONSEQ transfer from the current cycle, then runs the data phase to completion.
    task automatic doXfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [1:0] expResp, input logic [31:0] expRdata, input int expWaits);
        exp_t e, got;
        int   w;
        e.resp = expResp; e.rdata = expRdata; e.waits = expWaits;
        expQ.push_back(e);
        bus.iHSEL   = 1'b1;
        bus.iHTRANS = 2'b10;
        bus.iHADDR  = addr;
        bus.iHWRITE = wr;
        stepCycle();
        bus.iHSEL   = 1'b0;
        bus.iHTRANS = 2'b00;
        bus.iHWDATA = wdata;
        w = 0;
        while (bus.oHREADYOUT !== 1'b1 && w < 50) begin
            recordObs(w);
            w++;
            stepCycle();
            bus.iHWDATA = ~wdata;
        end
        recordObs(w);
        got = expQ.pop_front();
        checkVal("waits", 64'(w), 64'(got.waits));
        checkVal("hresp", 64'(bus.oHRESP), 64'(got.resp));
        checkVal("hrdata", 64'(bus.oHRDATA), 64'(got.rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pslvResp;
        logic [31:0] pslvData;
        int pslvWaits;
        bus.iHSEL = 1'b0; bus.iHADDR = '0; bus.iHTRANS = 2'b00; bus.iHWRITE = 1'b0;
        bus.iHSIZE = 3'b010; bus.iHWDATA = '0;

        repeat (3) stepCycle();
        checkVal("rst_hready", 64'(bus.oHREADYOUT), 64'd1);
        checkVal("rst_hresp_hrdata", {30'(bus.oHRESP), bus.oHRDATA}, 64'd0);
        checkVal("rst_apb", {bus.oPSEL, bus.oPENABLE, bus.oPWRITE, bus.oPADDR},
                 64'd0);
        checkVal("rst_pwdata", 64'(bus.oPWDATA), 64'd0);
        #2 rstN = 1'b1;
        stepCycle();

        // Read slave 1
        doXfer(32'h1000_0004, 1'b0, 32'h0, 2'b00, S1_DATA, 2);
        checkVal("rd_psel_t1", 64'(obsPsel[0]), 64'b10);
        checkVal("rd_pen_t1", 64'(obsPen[0]), 64'd0);
        checkVal("rd_pen_t2", 64'(obsPen[1]), 64'd1);
        checkVal("rd_paddr", 64'(obsPaddr[0]), 64'h1000_0004);
        checkVal("rd_pwrite", 64'(obsPwrite[1]), 64'd0);
        checkVal("rd_psel_done", 64'(obsPsel[2]), 64'd0);

        // Write slave 0
        doXfer(32'h0000_0010, 1'b1, 32'h1234_5678, 2'b00, S1_DATA, 3);
        checkVal("wr_psel_wdat", 64'(obsPsel[0]), 64'd0);
        checkVal("wr_psel_setup", 64'(obsPsel[1]), 64'b01);
        checkVal("wr_pen_setup", 64'(obsPen[1]), 64'd0);
        checkVal("wr_pwdata", 64'(obsPwdata[1]), 64'h1234_5678);
        checkVal("wr_pwrite", 64'(obsPwrite[1]), 64'd1);
        checkVal("wr_pen_access", 64'(obsPen[2]), 64'd1);
        checkVal("wr_pwdata_hold", 64'(bus.oPWDATA), 64'h1234_5678);

        // Read slave 0 with 3 PREADY-low ACCESS cycles
        stall0 = 3;
        doXfer(32'h0000_0008, 1'b0, 32'h0, 2'b00, S0_DATA, 5);
        for (int k = 1; k <= 4; k++) begin
            checkVal("ws_apb_stable", {obsPsel[k], obsPen[k], obsPwrite[k], obsPaddr[k]},
                     {2'b01, 1'b1, 1'b0, 32'h0000_0008});
        end
        stall0 = 0;

        // Decode miss, then back-to-back read accepted in ERR2
        doXfer(32'hF000_0000, 1'b0, 32'h0, 2'b01, S0_DATA, 1);
        checkVal("miss_psel", 64'(obsPsel[0]), 64'd0);
        checkVal("miss_err1", 64'(obsResp[0]), 64'b01);
        doXfer(32'h1000_0000, 1'b0, 32'h0, 2'b00, S1_DATA, 2);
        checkVal("b2b_psel", 64'(obsPsel[0]), 64'b10);

        // Slave error on a read of slave 0
`ifdef AHB_APB_PSLVERR_EN
        pslvResp = 2'b01; pslvData = S1_DATA; pslvWaits = 3;
`else
        pslvResp = 2'b00; pslvData = S0_DATA; pslvWaits = 2;
`endif
        slvErr = 2'b01;
        doXfer(32'h0000_0000, 1'b0, 32'h0, pslvResp, pslvData, pslvWaits);
        slvErr = 2'b00;

        // First index past NUM_SLV misses; last valid index decodes
        doXfer(32'h2000_0000, 1'b1, 32'hAAAA_5555, 2'b01, pslvData, 1);
        checkVal("miss2_psel", 64'(obsPsel[0]), 64'd0);
        doXfer(32'h1000_0020, 1'b1, 32'h0BAD_CAFE, 2'b00, pslvData, 3);
        checkVal("wr1_psel", 64'(obsPsel[1]), 64'b10);
        checkVal("wr1_pwdata", 64'(obsPwdata[2]), 64'h0BAD_CAFE);

        // IDLE and BUSY with HSEL high: no APB activity, zero-wait OKAY
        bus.iHSEL = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.iHTRANS = (k < 2) ? 2'b00 : 2'b01;
            bus.iHADDR  = 32'h1000_0000;
            stepCycle();
            checkVal("idle_busy", {bus.oPSEL, bus.oHREADYOUT, bus.oHRESP}, {2'b00, 1'b1, 2'b00});
        end
        bus.iHSEL = 1'b0; bus.iHTRANS = 2'b00;
        stepCycle();

        // Reset pulse mid-ACCESS
        stall0 = 20;
        bus.iHSEL = 1'b1; bus.iHTRANS = 2'b10; bus.iHADDR = 32'h0000_0004; bus.iHWRITE = 1'b0;
        stepCycle();
        bus.iHSEL = 1'b0; bus.iHTRANS = 2'b00;
        stepCycle();
        stepCycle();
        checkVal("pre_rst_access", {bus.oPENABLE, bus.oPSEL, bus.oHREADYOUT}, {1'b1, 2'b01, 1'b0});
        rstN = 1'b0;
        #1;
        checkVal("arst_apb", {bus.oPSEL, bus.oPENABLE, bus.oPWRITE, bus.oPADDR}, 64'd0);
        checkVal("arst_ahb", {bus.oHREADYOUT, bus.oHRESP, bus.oHRDATA}, {1'b1, 2'b00, 32'h0});
        checkVal("arst_pwdata", 64'(bus.oPWDATA), 64'd0);
        stepCycle();
        stall0 = 0;
        #2 rstN = 1'b1;
        stepCycle();
        doXfer(32'h1000_000C, 1'b0, 32'h0, 2'b00, S1_DATA, 2);
        checkVal("post_rst_psel", 64'(obsPsel[0]), 64'b10);

        checkVal("queue_empty", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
